// File: rtl/hcordic_vec_21.sv
// Hyperbolic CORDIC vectoring engine: atanh(y/x) and sqrt(x^2-y^2) in Q4.16, 18 iterations.
// Define HCORDIC_GAIN_COMP_EN to scale the magnitude output by ~1/0.82816.
module hcordic_vec_21 (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [20:0] x_in,
   input  logic signed [20:0] y_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [20:0] theta_out,
   output logic signed [20:0] mag_out,
   output logic               err
);

   // state | meaning
   // IDLE  | waiting for an operand, in_ready high
   // RUN   | one vectoring iteration per clock, idx = 0..17
   // DONE  | result (or domain error) presented until out_ready
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   logic signed [22:0] x_r, y_r, z_r;
   logic [4:0]         idx;

   logic [4:0]         sh;
   logic signed [22:0] atanh_v;
   logic signed [22:0] x_sh, y_sh, x_nx, y_nx, z_nx;
   logic signed [22:0] x_ext, y_ext, dom_lim, y_abs;
   logic signed [20:0] mag_nx;
   logic               dom_err;

   // Shift schedule 1..16 with 4 and 13 repeated for hyperbolic convergence.
   always_comb begin
      sh = 5'd1;
      case (idx)
         5'd0:  sh = 5'd1;
         5'd1:  sh = 5'd2;
         5'd2:  sh = 5'd3;
         5'd3:  sh = 5'd4;
         5'd4:  sh = 5'd4;
         5'd5:  sh = 5'd5;
         5'd6:  sh = 5'd6;
         5'd7:  sh = 5'd7;
         5'd8:  sh = 5'd8;
         5'd9:  sh = 5'd9;
         5'd10: sh = 5'd10;
         5'd11: sh = 5'd11;
         5'd12: sh = 5'd12;
         5'd13: sh = 5'd13;
         5'd14: sh = 5'd13;
         5'd15: sh = 5'd14;
         5'd16: sh = 5'd15;
         5'd17: sh = 5'd16;
         default: sh = 5'd1;
      endcase
   end

   // round(atanh(2^-i) * 2^16)
   always_comb begin
      atanh_v = 23'sd0;
      case (sh)
         5'd1:  atanh_v = 23'sd35999;
         5'd2:  atanh_v = 23'sd16739;
         5'd3:  atanh_v = 23'sd8235;
         5'd4:  atanh_v = 23'sd4101;
         5'd5:  atanh_v = 23'sd2049;
         5'd6:  atanh_v = 23'sd1024;
         5'd7:  atanh_v = 23'sd512;
         5'd8:  atanh_v = 23'sd256;
         5'd9:  atanh_v = 23'sd128;
         5'd10: atanh_v = 23'sd64;
         5'd11: atanh_v = 23'sd32;
         5'd12: atanh_v = 23'sd16;
         5'd13: atanh_v = 23'sd8;
         5'd14: atanh_v = 23'sd4;
         5'd15: atanh_v = 23'sd2;
         5'd16: atanh_v = 23'sd1;
         default: atanh_v = 23'sd0;
      endcase
   end

   always_comb begin
      x_sh = x_r >>> sh;
      y_sh = y_r >>> sh;
      if (y_r[22]) begin
         x_nx = x_r + y_sh;
         y_nx = y_r + x_sh;
         z_nx = z_r - atanh_v;
      end else begin
         x_nx = x_r - y_sh;
         y_nx = y_r - x_sh;
         z_nx = z_r + atanh_v;
      end
`ifdef HCORDIC_GAIN_COMP_EN
      mag_nx = 21'(x_nx + (x_nx >>> 2) - (x_nx >>> 5) - (x_nx >>> 7)
                   - (x_nx >>> 8) + (x_nx >>> 11));
`else
      mag_nx = x_nx[20:0];
`endif
   end

   // |y/x| limit of 0.78125 keeps the operand inside the convergence range.
   always_comb begin
      x_ext   = {{2{x_in[20]}}, x_in};
      y_ext   = {{2{y_in[20]}}, y_in};
      dom_lim = x_ext - (x_ext >>> 2) + (x_ext >>> 5);
      y_abs   = y_ext[22] ? -y_ext : y_ext;
      dom_err = (x_ext <= 23'sd0) || (y_abs > dom_lim);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         err       <= 1'b0;
         theta_out <= '0;
         mag_out   <= '0;
         x_r       <= '0;
         y_r       <= '0;
         z_r       <= '0;
         idx       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x_r      <= x_ext;
                  y_r      <= y_ext;
                  z_r      <= '0;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  if (dom_err) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     err       <= 1'b1;
                     theta_out <= '0;
                     mag_out   <= '0;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               x_r <= x_nx;
               y_r <= y_nx;
               z_r <= z_nx;
               if (idx == 5'd17) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  err       <= 1'b0;
                  theta_out <= z_nx[20:0];
                  mag_out   <= mag_nx;
               end else begin
                  idx <= idx + 5'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hcordic_vec_21.sv
// Bench for hcordic_vec_21: directed accuracy/handshake/reset cases plus random operands
// against an integer model of the hyperbolic vectoring rules with a runtime-computed atanh table.
module tb_hcordic_vec_21;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic signed [20:0] x_in;
   logic signed [20:0] y_in;
   logic               out_valid;
   logic               out_ready;
   logic signed [20:0] theta_out;
   logic signed [20:0] mag_out;
   logic               err;

   int n_tests = 0;
   int n_fail  = 0;
   int lut [1:16];
   int sh_tab [18] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14, 15, 16};

   always #5 clk = ~clk;

   hcordic_vec_21 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .y_in      (y_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .theta_out (theta_out),
      .mag_out   (mag_out),
      .err       (err)
   );

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int wrap(input int v, input int bits);
      return (v <<< (32 - bits)) >>> (32 - bits);
   endfunction

   function automatic int ash(input int v, input int s);
      return v >>> s;
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic void ref_model(input int x, input int y,
                                     output int th, output int mg, output bit e);
      int xx, yy, zz, d, xn, lim;
      th  = 0;
      mg  = 0;
      lim = x - x / 4 + x / 32;
      e   = (x <= 0) || (iabs(y) > lim);
      if (e) return;
      xx = x;
      yy = y;
      zz = 0;
      foreach (sh_tab[k]) begin
         d  = (yy < 0) ? 1 : -1;
         xn = wrap(xx + d * ash(yy, sh_tab[k]), 23);
         yy = wrap(yy + d * ash(xx, sh_tab[k]), 23);
         zz = wrap(zz - d * lut[sh_tab[k]], 23);
         xx = xn;
      end
      th = wrap(zz, 21);
`ifdef HCORDIC_GAIN_COMP_EN
      mg = wrap(xx + ash(xx, 2) - ash(xx, 5) - ash(xx, 7) - ash(xx, 8) + ash(xx, 11), 21);
`else
      mg = wrap(xx, 21);
`endif
   endfunction

   // Presents one operand, optionally stalls the result, then hands it off with in_valid
   // still asserted to show the handoff edge never doubles as an acceptance.
   task automatic run_op(input int x, input int y, input int stall,
                         output int th, output int mg, output bit e, output int lat);
      @(negedge clk);
      check_val("ready_idle", in_ready, 1);
      x_in     = x[20:0];
      y_in     = y[20:0];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      x_in = 21'($urandom);
      y_in = 21'($urandom);
      lat  = 0;
      if (!out_valid) check_val("ready_busy", in_ready, 0);
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         x_in = 21'($urandom);
         y_in = 21'($urandom);
      end
      th = int'(theta_out);
      mg = int'(mag_out);
      e  = err;
      for (int c = 0; c < stall; c++) begin
         @(posedge clk);
         #1;
         check_val("hold_valid", out_valid, 1);
         check_val("hold_theta", int'(theta_out), th);
         check_val("hold_mag", int'(mag_out), mg);
         check_val("hold_err", err, e);
         check_val("hold_ready", in_ready, 0);
      end
      x_in = 21'h00000;
      y_in = 21'h00000;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check_val("handoff_valid", out_valid, 0);
      check_val("handoff_ready", in_ready, 1);
   endtask

   task automatic run_check(input string tag, input int x, input int y, input int stall,
                            output int th, output int mg);
      int eth, emg, lat;
      bit ee, e;
      ref_model(x, y, eth, emg, ee);
      run_op(x, y, stall, th, mg, e, lat);
      check_val({tag, "_err"}, e, ee);
      check_val({tag, "_lat"}, lat, ee ? 0 : 18);
      check_val({tag, "_theta"}, th, eth);
      check_val({tag, "_mag"}, mg, emg);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int th, mg, x, y, lim, unit_mag;
      for (int i = 1; i <= 16; i++)
         lut[i] = int'($floor($atanh(1.0 / (2.0 ** i)) * 65536.0 + 0.5));
`ifdef HCORDIC_GAIN_COMP_EN
      unit_mag = 65536;
`else
      unit_mag = 54274;
`endif

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x_in      = '0;
      y_in      = '0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_ready", in_ready, 1);
      check_val("rst_valid", out_valid, 0);
      check_val("rst_err", err, 0);
      check_val("rst_theta", int'(theta_out), 0);
      check_val("rst_mag", int'(mag_out), 0);
      rst_n = 1'b1;

      run_check("unit", 32'h10000, 0, 0, th, mg);
      check_val("unit_theta_tol", iabs(th) <= 4, 1);
      check_val("unit_mag_tol", iabs(mg - unit_mag) <= 8, 1);

      run_check("half_pos", 73900, 34151, 0, th, mg);
      check_val("half_pos_theta_tol", iabs(th - 32768) <= 8, 1);
      check_val("half_pos_mag_tol", iabs(mg - unit_mag) <= 8, 1);
      run_check("half_neg", 73900, -34151, 0, th, mg);
      check_val("half_neg_theta_tol", iabs(th + 32768) <= 8, 1);

      run_check("err_eq", 32'h10000, 32'h10000, 0, th, mg);
      run_check("err_zero", 0, 0, 0, th, mg);
      run_check("err_negx", -70000, 100, 0, th, mg);
      run_check("edge_in", 32'h10000, 51200, 0, th, mg);
      run_check("edge_out", 32'h10000, 51201, 0, th, mg);
      run_check("edge_outn", 32'h10000, -51201, 0, th, mg);

      run_check("stall", 80000, 20000, 5, th, mg);

      // abandon an operation partway through RUN
      @(negedge clk);
      x_in     = 21'd73900;
      y_in     = 21'd34151;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_val("midrst_ready", in_ready, 1);
      check_val("midrst_valid", out_valid, 0);
      check_val("midrst_err", err, 0);
      check_val("midrst_theta", int'(theta_out), 0);
      check_val("midrst_mag", int'(mag_out), 0);
      run_check("after_rst", 90000, -40000, 0, th, mg);

      for (int n = 0; n < 30; n++) begin
         x   = int'($urandom_range(1024, 1000000));
         lim = x - x / 4 + x / 32;
         y   = int'($urandom_range(0, lim + lim / 8));
         if ($urandom_range(0, 1) == 1) y = -y;
         if ($urandom_range(0, 9) == 0) x = -x;
         run_check("rand", x, y, int'($urandom_range(0, 2)), th, mg);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hcordic_vec_21.md
HCORDIC_VEC_21 -- requirements
Module: hcordic_vec_21

Interface
REQ-001 SHALL have one clock `clk`; reset is synchronous and active-low (`rst_n`), sampled on rising `clk`.
REQ-002 Port list (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept an operand
- x_in  in  21  signed Q4.16 X (cosh-like); 1.0 = 0x10000
- y_in  in  21  signed Q4.16 Y (sinh-like)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- theta_out  out  21  signed Q4.16 atanh(y_in/x_in)
- mag_out  out  21  signed Q4.16 sqrt(x_in^2 - y_in^2)
- err  out  1  operand outside the convergence domain

Function
REQ-003 SHALL implement a three-state FSM (IDLE, RUN, DONE): in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-004 SHALL accept an operand on a rising edge with in_valid&&in_ready, registering x_in and y_in sign-extended to 23-bit internal X/Y, and clearing internal Z and the iteration index.
REQ-005 SHALL flag a domain error at acceptance if x_in<=0 or |y_in| > x_in - (x_in>>>2) + (x_in>>>5), i.e. |y/x| > 0.78125.
- On error, go directly to DONE with err=1, theta_out=0, mag_out=0; out_valid rises in the cycle after the acceptance edge.
REQ-006 Without error, SHALL enter RUN and perform exactly one hyperbolic vectoring iteration per clock, 18 iterations total.
- Shift sequence: 1,2,3,4,4,5,...,13,13,14,15,16 (4 and 13 repeated).
REQ-007 Each iteration, with d=+1 when Y<0 and d=-1 otherwise:
- X' = X + d*(Y>>>i)
- Y' = Y + d*(X>>>i)
- Z' = Z - d*atanh_lut(i)
- All shifts are arithmetic; 23-bit two's-complement wrap-around; no saturation.
REQ-008 atanh_lut(i) SHALL equal round(atanh(2^-i)*2^16) for i=1..16, e.g. i=1 -> 35999 and i=2 -> 16739; a repeated index reuses the same entry.
REQ-009 After the 18th iteration edge SHALL enter DONE, giving out_valid 18 cycles after acceptance:
- theta_out = Z[20:0]
- mag_out as per REQ-013/014
- err = 0
REQ-010 In DONE, outputs SHALL hold stable until out_valid&&out_ready.
- Then return to IDLE with out_valid=0.
- in_ready rises the cycle after.
- No acceptance occurs in the same cycle as a result handoff.
REQ-011 in_valid, x_in and y_in SHALL be ignored outside IDLE; changes to operands during RUN do not affect the result.

Reset
REQ-012 With rst_n=0 at a rising edge, the block SHALL:
- enter IDLE
- clear in_ready to 1, out_valid to 0, err to 0, theta_out/mag_out to 0, and internal X/Y/Z and the index to 0
- apply this from any state, including mid-RUN, and abandon the operation in flight.

Configuration
REQ-013 With macro HCORDIC_GAIN_COMP_EN defined, mag_out SHALL be X_final scaled by ~1/0.82816 using the shift-add X + X>>>2 - X>>>5 - X>>>7 - X>>>8 + X>>>11 (about 1.2075), truncated to 21 bits.
REQ-014 Without HCORDIC_GAIN_COMP_EN, mag_out SHALL be the raw X_final[20:0] (about 0.82816*true magnitude). Latency is identical in both builds.

Verification
REQ-015 x_in=0x10000, y_in=0 -> after 18 cycles out_valid=1, theta_out=0 +/-4 LSB, mag_out=65536 +/-8 LSB (GAIN_COMP on), err=0.
REQ-016 x_in=73900 (cosh 0.5), y_in=34151 (sinh 0.5) -> theta_out=32768 +/-8 LSB, mag_out=65536 +/-8 LSB; repeat with y_in=-34151 -> theta_out=-32768 +/-8 LSB.
REQ-017 x_in=0x10000, y_in=0x10000, and separately x_in=0, y_in=0 -> out_valid one cycle after acceptance, err=1, theta_out=0, mag_out=0.
REQ-018 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, theta_out, mag_out and err stay constant and in_ready stays 0; then pulse out_ready=1 for one cycle -> IDLE and in_ready=1 on the next cycle.
REQ-019 Reset mid-operation: assert rst_n=0 for one edge at iteration 9 of a RUN -> next cycle shows IDLE, in_ready=1, out_valid=0 and zeroed outputs; a new operand then completes correctly in 18 cycles.
REQ-020 Build without HCORDIC_GAIN_COMP_EN; x_in=0x10000, y_in=0 -> mag_out=54274 +/-8 LSB, theta_out=0 +/-4 LSB.
